// File: rtl/id_ex_control_stage.sv
// id_ex_control_stage: RISC-V main decode plus ID/EX control register with stall, flush and illegal-opcode tracking
// Inputs : clk, reset (sync, active-high), instr, instr_valid, stall (hold), flush (bubble)
// Outputs: ex_* registered control bits and ALU decoder fields, ex_illegal pulse, ill_count saturating counter
module id_ex_control_stage #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [1:0]           ex_ALUOp,
  output logic [2:0]           ex_Funct3,
  output logic [6:0]           ex_Funct7,
  output logic                 ex_ALUSrc,
  output logic                 ex_MemRead,
  output logic                 ex_MemWrite,
  output logic                 ex_MemtoReg,
  output logic                 ex_RegWrite,
  output logic                 ex_Branch,
  output logic                 ex_Jump,
  output logic                 ex_JalrSel,
  output logic [1:0]           ex_RWSel,
  output logic                 ex_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  logic [6:0]           w_op;
  logic [2:0]           w_f3;
  logic [6:0]           w_f7;
  logic [11:0]          w_ctl;
  logic                 w_legal;
  logic                 w_load;
  logic                 w_ill;
  logic                 w_unused;
  logic                 r_valid;
  logic [11:0]          r_ctl;
  logic [2:0]           r_f3;
  logic [6:0]           r_f7;
  logic                 r_illegal;
  logic [ILL_CNT_W-1:0] r_cnt;
  assign w_op = instr[6:0];
  assign w_f3 = instr[14:12];
  assign w_unused = ^instr[24:15];
  // w_ctl = {ALUOp, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch, Jump, JalrSel, RWSel}
  always_comb begin
    w_legal = 1'b1;
    case (w_op)
      OP_R:       w_ctl = 12'b10_0_0_0_0_1_0_0_0_00;
      OP_I:       w_ctl = 12'b10_1_0_0_0_1_0_0_0_00;
      7'b0000011: w_ctl = 12'b00_1_1_0_1_1_0_0_0_00;
      7'b0100011: w_ctl = 12'b00_1_0_1_0_0_0_0_0_00;
      7'b1100011: w_ctl = 12'b01_0_0_0_0_0_1_0_0_00;
      7'b1101111: w_ctl = 12'b11_0_0_0_0_1_0_1_0_01;
      7'b1100111: w_ctl = 12'b00_1_0_0_0_1_0_1_1_01;
      7'b0110111: w_ctl = 12'b11_1_0_0_0_1_0_0_0_10;
      7'b0010111: w_ctl = 12'b00_1_0_0_0_1_0_0_0_11;
      default: begin
        w_ctl = '0;
        w_legal = 1'b0;
      end
    endcase
  end
  // Non-shift I-ALU ops get Funct7 all-ones so the ALU decoder picks the immediate form
  assign w_f7 = (w_op == OP_R) ? instr[31:25] :
                (w_op == OP_I) ? ((w_f3 == 3'b001 || w_f3 == 3'b101) ? instr[31:25] : 7'h7F) : 7'h00;
  assign w_load = instr_valid & w_legal;
  assign w_ill = instr_valid & ~w_legal;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctl <= '0;
      r_f3 <= '0;
      r_f7 <= '0;
      r_illegal <= 1'b0;
      r_cnt <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctl <= '0;
      r_f3 <= '0;
      r_f7 <= '0;
      r_illegal <= 1'b0;
    end else if (!stall) begin
      r_valid <= w_load;
      r_ctl <= w_load ? w_ctl : '0;
      r_f3 <= w_load ? w_f3 : '0;
      r_f7 <= w_load ? w_f7 : '0;
      r_illegal <= w_ill;
      if (w_ill && !(&r_cnt)) r_cnt <= r_cnt + ILL_CNT_W'(1);
    end
  end
  assign ex_valid = r_valid;
  assign {ex_ALUOp, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_RegWrite,
          ex_Branch, ex_Jump, ex_JalrSel, ex_RWSel} = r_ctl;
  assign ex_Funct3 = r_f3;
  assign ex_Funct7 = r_f7;
  assign ex_illegal = r_illegal;
  assign ill_count = r_cnt;
endmodule
